// File: rtl/addr_mode_seq.sv
// addr_mode_seq: 6502 effective-address sequencer.
// It fetches operand bytes, drives the shared ALU to form the address, and returns
// the 16-bit effective address together with a one-cycle done pulse.
// Optional feature macro: PAGE_CROSS_EN. It inserts the PENALTY state and reports page_cross_o.

package addr_mode_seq_pkg;
  typedef enum logic [1:0] {
    ALU_BYPASS_A     = 2'd0,
    ALU_ADD          = 2'd1,
    ALU_ADD_ZEROPAGE = 2'd2
  } alu_op_t;

  localparam logic [3:0] MODE_IMM  = 4'd0;
  localparam logic [3:0] MODE_ZP   = 4'd1;
  localparam logic [3:0] MODE_ZPX  = 4'd2;
  localparam logic [3:0] MODE_ZPY  = 4'd3;
  localparam logic [3:0] MODE_ABS  = 4'd4;
  localparam logic [3:0] MODE_ABSX = 4'd5;
  localparam logic [3:0] MODE_ABSY = 4'd6;
  localparam logic [3:0] MODE_INDX = 4'd7;
  localparam logic [3:0] MODE_INDY = 4'd8;
endpackage

module addr_mode_seq
  import addr_mode_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [3:0]  mode_i,
  input  logic [15:0] pc_i,
  input  logic [7:0]  x_i,
  input  logic [7:0]  y_i,
  output logic        mem_rd_o,
  output logic [15:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i,
  output alu_op_t     alu_op_o,
  output logic [15:0] alu_op_a_o,
  output logic [15:0] alu_op_b_o,
  input  logic [15:0] alu_res_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] ea_o,
  output logic [15:0] next_pc_o,
  output logic        page_cross_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_OPR_LO  = 3'd1;
  localparam logic [2:0] S_OPR_HI  = 3'd2;
  localparam logic [2:0] S_IDX     = 3'd3;
  localparam logic [2:0] S_PTR_LO  = 3'd4;
  localparam logic [2:0] S_PTR_HI  = 3'd5;
  localparam logic [2:0] S_PENALTY = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [3:0]  mode_q, mode_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  lo_q, lo_d, hi_q, hi_d, ptr_q, ptr_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] ea_q, ea_d, npc_q, npc_d;
  logic        pcx_q, pcx_d, done_q, done_d, busy_q, busy_d;

  logic [7:0]  idx_c;
  logic        zp_idx_c, two_byte_c;
  logic [15:0] pc_inc1_c;
  logic        fin_c, fin_pcx_c;
  logic [15:0] fin_ea_c, fin_npc_c;

  // Mode-derived helpers and the dedicated PC incrementer
  assign idx_c      = (mode_q == MODE_ZPY || mode_q == MODE_ABSY || mode_q == MODE_INDY) ? y_q : x_q;
  assign zp_idx_c   = (mode_q == MODE_ZPX || mode_q == MODE_ZPY || mode_q == MODE_INDX);
  assign two_byte_c = (mode_q == MODE_ABS || mode_q == MODE_ABSX || mode_q == MODE_ABSY);
  assign pc_inc1_c  = 16'(pc_q + 16'd1);

  // ALU request decode; depends on registered state only
  always_comb begin
    alu_op_o   = ALU_BYPASS_A;
    alu_op_a_o = 16'h0000;
    alu_op_b_o = 16'h0000;
    case (state_q)
      S_IDX: begin
        alu_op_b_o = {8'h00, idx_c};
        if (zp_idx_c) begin
          alu_op_o   = ALU_ADD_ZEROPAGE;
          alu_op_a_o = {8'h00, lo_q};
        end else begin
          alu_op_o   = ALU_ADD;
          alu_op_a_o = {hi_q, lo_q};
        end
      end
      S_PTR_HI: begin
        alu_op_o   = ALU_ADD_ZEROPAGE;
        alu_op_a_o = {8'h00, ptr_q};
        alu_op_b_o = 16'h0001;
      end
      default: ;
    endcase
  end

  // Memory read decode; the pointer high-byte address comes from the zero-page ALU add
  always_comb begin
    mem_rd_o   = 1'b0;
    mem_addr_o = 16'h0000;
    case (state_q)
      S_OPR_LO: begin mem_rd_o = 1'b1; mem_addr_o = pc_q; end
      S_OPR_HI: begin mem_rd_o = 1'b1; mem_addr_o = pc_inc1_c; end
      S_PTR_LO: begin mem_rd_o = 1'b1; mem_addr_o = {8'h00, ptr_q}; end
      S_PTR_HI: begin mem_rd_o = 1'b1; mem_addr_o = alu_res_i; end
      default: ;
    endcase
  end

  // Next-state logic and result capture
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pc_d      = pc_q;
    x_d       = x_q;
    y_d       = y_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    ptr_d     = ptr_q;
    sum_d     = sum_q;
    ea_d      = ea_q;
    npc_d     = npc_q;
    pcx_d     = pcx_q;
    fin_c     = 1'b0;
    fin_ea_c  = 16'h0000;
    fin_pcx_c = 1'b0;
    fin_npc_c = two_byte_c ? 16'(pc_q + 16'd2) : pc_inc1_c;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d = (mode_i > MODE_INDY) ? MODE_IMM : mode_i;
          pc_d   = pc_i;
          x_d    = x_i;
          y_d    = y_i;
          if (mode_d == MODE_IMM) begin
            fin_c     = 1'b1;
            fin_ea_c  = pc_i;
            fin_npc_c = 16'(pc_i + 16'd1);
          end else begin
            state_d = S_OPR_LO;
          end
        end
      end
      S_OPR_LO: begin
        lo_d  = mem_rdata_i;
        ptr_d = mem_rdata_i;
        case (mode_q)
          MODE_ZP: begin
            fin_c    = 1'b1;
            fin_ea_c = {8'h00, mem_rdata_i};
          end
          MODE_ZPX, MODE_ZPY, MODE_INDX: state_d = S_IDX;
          MODE_INDY:                     state_d = S_PTR_LO;
          default:                       state_d = S_OPR_HI;
        endcase
      end
      S_OPR_HI: begin
        hi_d = mem_rdata_i;
        if (mode_q == MODE_ABS) begin
          fin_c    = 1'b1;
          fin_ea_c = {mem_rdata_i, lo_q};
        end else begin
          state_d = S_IDX;
        end
      end
      S_IDX: begin
        if (mode_q == MODE_INDX) begin
          ptr_d   = alu_res_i[7:0];
          state_d = S_PTR_LO;
        end else if (zp_idx_c) begin
          fin_c    = 1'b1;
          fin_ea_c = alu_res_i;
        end else begin
`ifdef PAGE_CROSS_EN
          if (alu_res_i[15:8] != hi_q) begin
            sum_d   = alu_res_i;
            state_d = S_PENALTY;
          end else begin
            fin_c    = 1'b1;
            fin_ea_c = alu_res_i;
          end
`else
          fin_c    = 1'b1;
          fin_ea_c = alu_res_i;
`endif
        end
      end
      S_PTR_LO: begin
        lo_d    = mem_rdata_i;
        state_d = S_PTR_HI;
      end
      S_PTR_HI: begin
        hi_d = mem_rdata_i;
        if (mode_q == MODE_INDX) begin
          fin_c    = 1'b1;
          fin_ea_c = {mem_rdata_i, lo_q};
        end else begin
          state_d = S_IDX;
        end
      end
      S_PENALTY: begin
        fin_c    = 1'b1;
        fin_ea_c = sum_q;
`ifdef PAGE_CROSS_EN
        fin_pcx_c = 1'b1;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fin_c) begin
      state_d = S_DONE;
      ea_d    = fin_ea_c;
      npc_d   = fin_npc_c;
      pcx_d   = fin_pcx_c;
    end
  end

  assign done_d = (state_d == S_DONE);
  assign busy_d = (state_d != S_IDLE);

  // State and result registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      mode_q  <= 4'h0;
      pc_q    <= 16'h0000;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      ptr_q   <= 8'h00;
      sum_q   <= 16'h0000;
      ea_q    <= 16'h0000;
      npc_q   <= 16'h0000;
      pcx_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pc_q    <= pc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      ea_q    <= ea_d;
      npc_q   <= npc_d;
      pcx_q   <= pcx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign ea_o         = ea_q;
  assign next_pc_o    = npc_q;
  assign page_cross_o = pcx_q;

endmodule

// File: tb/tb_addr_mode_seq.sv
// Directed bench for addr_mode_seq with a behavioural memory and ALU.
module tb_addr_mode_seq;
  import addr_mode_seq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  mode_i = 4'h0;
  logic [15:0] pc_i = 16'h0000;
  logic [7:0]  x_i = 8'h00, y_i = 8'h00;
  logic        mem_rd_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_rdata_i;
  alu_op_t     alu_op_o;
  logic [15:0] alu_op_a_o, alu_op_b_o, alu_res_i;
  logic        busy_o, done_o, page_cross_o;
  logic [15:0] ea_o, next_pc_o;

  logic [7:0]  mem [65536];
  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int zp_cnt = 0;
  int last_rd, last_zp;

`ifdef PAGE_CROSS_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  always #5 clk_i = ~clk_i;

  addr_mode_seq dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .mode_i(mode_i),
    .pc_i(pc_i), .x_i(x_i), .y_i(y_i), .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .alu_op_o(alu_op_o), .alu_op_a_o(alu_op_a_o),
    .alu_op_b_o(alu_op_b_o), .alu_res_i(alu_res_i), .busy_o(busy_o), .done_o(done_o),
    .ea_o(ea_o), .next_pc_o(next_pc_o), .page_cross_o(page_cross_o)
  );

  assign mem_rdata_i = mem[mem_addr_o];

  always_comb begin
    case (alu_op_o)
      ALU_ADD:          alu_res_i = 16'(alu_op_a_o + alu_op_b_o);
      ALU_ADD_ZEROPAGE: alu_res_i = {8'h00, 8'(alu_op_a_o[7:0] + alu_op_b_o[7:0])};
      default:          alu_res_i = alu_op_a_o;
    endcase
  end

  always @(posedge clk_i) begin
    if (mem_rd_o) rd_cnt <= rd_cnt + 1;
    if (alu_op_o == ALU_ADD_ZEROPAGE) zp_cnt <= zp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction: drive, wait for done, check results and the pulse dropping.
  task automatic run(input string tag, input logic [3:0] m, input logic [15:0] pc,
                     input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp_ea,
                     input logic [15:0] exp_npc, input logic exp_pcx, input int exp_cyc);
    int cyc;
    int rd0, zp0;
    @(negedge clk_i);
    rd0 = rd_cnt; zp0 = zp_cnt;
    start_i = 1'b1; mode_i = m; pc_i = pc; x_i = x; y_i = y;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 20) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_ea"}, 32'(ea_o), 32'(exp_ea));
    check({tag, "_npc"}, 32'(next_pc_o), 32'(exp_npc));
    check({tag, "_pcx"}, 32'(page_cross_o), 32'(exp_pcx));
    @(posedge clk_i); #1;
    check({tag, "_done_low"}, 32'(done_o), 32'd0);
    check({tag, "_idle"}, 32'(busy_o), 32'd0);
    last_rd = rd_cnt - rd0;
    last_zp = zp_cnt - zp0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0200] = 8'hF0;
    mem[16'h0300] = 8'hFF; mem[16'h0301] = 8'h12;
    mem[16'h0400] = 8'hFE; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    mem[16'h0500] = 8'h40; mem[16'h0040] = 8'h00; mem[16'h0041] = 8'h30;
    mem[16'h0600] = 8'h77;
    mem[16'h0700] = 8'hCD; mem[16'h0701] = 8'hAB;
    mem[16'h0800] = 8'hFF; mem[16'h0801] = 8'hFF;
    mem[16'h0900] = 8'hFF;
    mem[16'h0A00] = 8'h11; mem[16'h0A01] = 8'h22;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ea", 32'(ea_o), 32'd0);
    check("rst_npc", 32'(next_pc_o), 32'd0);
    check("rst_pcx", 32'(page_cross_o), 32'd0);
    check("rst_rd", 32'(mem_rd_o), 32'd0);
    check("rst_alu", 32'(alu_op_o), 32'(ALU_BYPASS_A));
    @(negedge clk_i);
    rstn_i = 1'b1;

    run("imm", MODE_IMM, 16'h8000, 8'h00, 8'h00, 16'h8000, 16'h8001, 1'b0, 1);
    check("imm_no_rd", 32'(last_rd), 32'd0);
    run("zpx", MODE_ZPX, 16'h0200, 8'h20, 8'h00, 16'h0010, 16'h0201, 1'b0, 3);
    check("zpx_zpop", 32'(last_zp), 32'd1);
    run("absy", MODE_ABSY, 16'h0300, 8'h00, 8'h01, 16'h1300, 16'h0302, 1'(PEN), 4 + PEN);
    check("absy_rd", 32'(last_rd), 32'd2);
    run("indx", MODE_INDX, 16'h0400, 8'h01, 8'h00, 16'h1234, 16'h0401, 1'b0, 5);
    check("indx_rd", 32'(last_rd), 32'd3);
    check("indx_zpop", 32'(last_zp), 32'd2);
    run("indy", MODE_INDY, 16'h0500, 8'h00, 8'h05, 16'h3005, 16'h0501, 1'b0, 5);
    run("zp", MODE_ZP, 16'h0600, 8'h00, 8'h00, 16'h0077, 16'h0601, 1'b0, 2);
    run("abs", MODE_ABS, 16'h0700, 8'h00, 8'h00, 16'hABCD, 16'h0702, 1'b0, 3);
    run("absx_wrap", MODE_ABSX, 16'h0800, 8'h01, 8'h00, 16'h0000, 16'h0802, 1'(PEN), 4 + PEN);
    run("zpy_wrap", MODE_ZPY, 16'h0900, 8'h00, 8'h02, 16'h0001, 16'h0901, 1'b0, 3);
    run("mode12", 4'd12, 16'h1234, 8'h00, 8'h00, 16'h1234, 16'h1235, 1'b0, 1);

    // Reset during cycle 2 of an ABS sequence
    @(negedge clk_i);
    start_i = 1'b1; mode_i = MODE_ABS; pc_i = 16'h0A00;
    @(posedge clk_i);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_ea", 32'(ea_o), 32'd0);
    check("abort_npc", 32'(next_pc_o), 32'd0);
    check("abort_rd", 32'(mem_rd_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    check("abort_no_done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // ABS with start held through busy, then a back-to-back IMM
    @(negedge clk_i);
    start_i = 1'b1; mode_i = MODE_ABS; pc_i = 16'h0A00;
    @(posedge clk_i); #1;
    mode_i = MODE_IMM; pc_i = 16'hBEEF;
    cyc = 1;
    while (!done_o && cyc < 20) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("held_cyc", 32'(cyc), 32'd3);
    check("held_ea", 32'(ea_o), 32'h2211);
    check("held_npc", 32'(next_pc_o), 32'h0A02);
    pc_i = 16'h4444;
    @(posedge clk_i); #1;
    check("b2b_idle", 32'(busy_o), 32'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("b2b_done", 32'(done_o), 32'd1);
    check("b2b_ea", 32'(ea_o), 32'h4444);
    check("b2b_npc", 32'(next_pc_o), 32'h4445);
    @(posedge clk_i); #1;
    check("b2b_end", 32'(busy_o | done_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
